// File: rtl/fifo_rd_drain.sv
// Read-side adapter: pops a one-cycle-latency FIFO into a 2-entry buffer and
// presents words on a valid/ready stream, counting delivered words.
module fifo_rd_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      word_cnt,
  output logic                  busy
);

  // DEPTH describes the attached FIFO only; nothing here is sized by it.
  if (DEPTH == 0) begin : g_depth_unused
  end

  logic [1:0]            occ_q, occ_d, occ_sh;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  m_valid_q, m_valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  hs_c;
  logic                  rd_en_c;
  logic [2:0]            lvl_c;

  // Pop whenever the buffer plus the word in flight leaves room after this handshake.
  always_comb begin
    hs_c    = m_valid_q && m_ready;
    lvl_c   = 3'(occ_q) + 3'(inflight_q) - 3'(hs_c);
    rd_en_c = !rst && !fifo_empty && (lvl_c < 3'd2);
  end

  assign fifo_rd_en = rd_en_c;

  // Retire the head on a handshake, then land any arriving word in the first free slot.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_sh     = occ_q;
    if (hs_c) begin
      occ_sh = occ_q - 2'd1;
      if (occ_q == 2'd2) begin
        head_d = tail_q;
      end
    end
    if (inflight_q) begin
      if (occ_sh == 2'd0) begin
        head_d = fifo_dout;
      end else begin
        tail_d = fifo_dout;
      end
    end
    occ_d      = occ_sh + 2'(inflight_q);
    inflight_d = rd_en_c;
    m_valid_d  = (occ_d != 2'd0);
    cnt_d      = hs_c ? cnt_q + CNT_W'(1) : cnt_q;
    busy_d     = (occ_d != 2'd0) || inflight_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      m_valid_q  <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      m_valid_q  <= m_valid_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = head_q;
  assign word_cnt = cnt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: behavioural FIFO in front, scoreboard on the stream side.
module tb_fifo_rd_drain;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [15:0]   word_cnt;
  logic          busy;

  logic          e4 = 1'b1;
  logic          rd_en4;
  logic [DW-1:0] dout4 = 8'hC3;
  logic          m_valid4;
  logic [DW-1:0] m_data4;
  logic          m_ready4 = 1'b1;
  logic [3:0]    word_cnt4;
  logic          busy4;

  logic [DW-1:0] fmem[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pop_w;
  logic [DW-1:0] prev_data = '0;
  logic          stall_prev = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            rd_pulses = 0;
  int            rd4 = 0;
  int            hs4 = 0;
  int            base;

  always #5 clk = ~clk;

  fifo_rd_drain #(.DATA_WIDTH(DW), .DEPTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .word_cnt(word_cnt), .busy(busy)
  );

  fifo_rd_drain #(.DATA_WIDTH(DW), .DEPTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .fifo_empty(e4), .fifo_rd_en(rd_en4),
    .fifo_dout(dout4), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready4),
    .word_cnt(word_cnt4), .busy(busy4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural FIFO with registered read data
  always @(posedge clk) begin
    if (rst) begin
      fmem.delete();
      fifo_dout <= '0;
    end else begin
      if (fifo_rd_en && fmem.size() != 0) begin
        pop_w = fmem.pop_front();
        fifo_dout <= pop_w;
      end
      if (wr_en) fmem.push_back(wr_data);
    end
    fifo_empty <= rst || (fmem.size() == 0);
    if (!rst && fifo_rd_en) rd_pulses++;
    if (!rst && rd_en4) rd4++;
    if (!rst && m_valid4 && m_ready4) hs4++;
  end

  // Stream monitor: scoreboard, hold-under-backpressure, no pop from empty
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
      if (stall_prev) begin
        check_eq("hold_valid", 32'(m_valid), 32'd1);
        check_eq("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_word(input logic [DW-1:0] d);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || m_valid || !fifo_empty) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", 32'(n < 200), 32'd1);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_data", 32'(m_data), 32'd0);
    check_eq("rst_cnt", 32'(word_cnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // three words, latency and back-to-back delivery
    m_ready = 1'b1;
    push_word(8'h11);
    push_word(8'h22);
    @(negedge clk);
    check_eq("lat_n_rd_en", 32'(fifo_rd_en), 32'd1);
    check_eq("lat_n_valid", 32'(m_valid), 32'd0);
    push_word(8'h33);
    @(negedge clk);
    check_eq("lat_n1_valid", 32'(m_valid), 32'd0);
    idle_cycles(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t1_no_bubble", 32'(m_valid), 32'd1);
    end
    wait_idle();
    check_eq("t1_cnt", 32'(word_cnt), 32'd3);
    check_eq("t1_busy", 32'(busy), 32'd0);

    // backpressure: only two pops ahead of delivery
    m_ready = 1'b0;
    base = rd_pulses;
    for (int i = 0; i < 8; i++) push_word(8'(i));
    idle_cycles(10);
    check_eq("bp_rd_pulses", 32'(rd_pulses - base), 32'd2);
    check_eq("bp_valid", 32'(m_valid), 32'd1);
    check_eq("bp_data", 32'(m_data), 32'h00);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("bp_no_bubble", 32'(m_valid), 32'd1);
    end
    wait_idle();
    check_eq("bp_cnt", 32'(word_cnt), 32'd11);

    // toggling ready with continuous feed
    for (int i = 0; i < 16; i++) begin
      push_word(8'hA0 + 8'(i));
      m_ready = (i % 2) == 0;
    end
    idle_cycles(1);
    m_ready = 1'b1;
    wait_idle();
    check_eq("tog_cnt", 32'(word_cnt), 32'd27);

    // reset with a full buffer
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hB0 + 8'(i));
    idle_cycles(4);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_valid", 32'(m_valid), 32'd0);
    check_eq("post_rst_cnt", 32'(word_cnt), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    m_ready = 1'b1;
    push_word(8'h5A);
    idle_cycles(1);
    wait_idle();
    check_eq("post_rst_word_cnt", 32'(word_cnt), 32'd1);

    // FIFO runs dry mid-stream, then refills
    push_word(8'h01);
    push_word(8'h02);
    idle_cycles(1);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("gap_valid_low", 32'(m_valid), 32'd0);
    end
    push_word(8'h03);
    idle_cycles(1);
    wait_idle();
    check_eq("gap_cnt", 32'(word_cnt), 32'd4);

    // 4-bit counter wraps after 16 words
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      e4 = (rd4 >= 17);
      if (hs4 == 16) check_eq("cnt4_wrap", 32'(word_cnt4), 32'd0);
    end
    check_eq("cnt4_hs", 32'(hs4), 32'd17);
    check_eq("cnt4_final", 32'(word_cnt4), 32'd1);
    check_eq("cnt4_busy", 32'(busy4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
